frogger_player_ctrl: RTL and testbench
======================================

// Module: frogger_player_ctrl
// PURPOSE
//  Player-control core for the Frogger game.
//  - Turns four debounced direction buttons into one-tile moves of the frog on a 14x13 tile grid.
//  - Detects arrival on a lily pad, increments a saturating score and respawns the frog at the start tile.
//  - Reports whether the tile currently being scanned by the VGA counters holds the frog.
//  - Sits between the button debouncers, the VGA tile counters and the video mux / score_control.
// PARAMETERS
//  GAME_WIDTH   14  grid columns, X range 0..13
//  GAME_HEIGHT  13  grid rows, Y range 0..12; row 0 is the goal row
//  START_X      6   respawn column
//  START_Y      12  respawn row (bottom grass)
//  SCORE_LIMIT  99  score saturation value
// PORTS
//  i_Clk            in   1  system/pixel clock; all registers on rising edge
//  i_Rst            in   1  synchronous, active-high reset
//  i_Game_Active    in   1  1 = play enabled; 0 = frog held at start tile
//  i_Up_Mvt         in   1  debounced level, up button (Y-1)
//  i_Down_Mvt       in   1  debounced level, down button (Y+1)
//  i_Left_Mvt       in   1  debounced level, left button (X-1)
//  i_Right_Mvt      in   1  debounced level, right button (X+1)
//  i_Score          in   7  externally held score, fed back from o_Score; used for the limit check
//  i_Col_Count_Div  in   5  current VGA column / 32 (tile column)
//  i_Row_Count_Div  in   5  current VGA row / 32 (tile row)
//  o_Draw_Frogger   out  1  1 when the scanned tile equals the frog tile
//  o_Frogger_X      out  6  frog tile column, registered
//  o_Frogger_Y      out  6  frog tile row, registered
//  o_Score          out  7  registered score, 0..SCORE_LIMIT
// BEHAVIOUR
//  Reset:
//   - X=START_X, Y=START_Y, o_Score=0.
//   - Button history registers set to 1, so a button held through reset release causes no move.
//  Edge detection:
//   - Each button has a 1-bit history register that updates every clock, even while the game is inactive.
//   - A move request is current=1 AND history=0.
//  Move rules:
//   - Moves happen only when i_Game_Active=1.
//   - At most one move per cycle. Priority when requests coincide: Up > Down > Left > Right.
//   - Latency: the request sampled at clock edge k updates X/Y at that same edge.
//  Bounds (request ignored, position unchanged):
//   - Up at Y=0; Down at Y=GAME_HEIGHT-1.
//   - Left at X=0; Right at X=GAME_WIDTH-1.
//  Goal row:
//   - Up from Y=1 into an odd column (wall) is ignored.
//   - Up from Y=1 into an even column (lily pad):
//     - X/Y reload START_X/START_Y in that cycle.
//     - o_Score <= i_Score+1 if i_Score < SCORE_LIMIT, otherwise it holds at SCORE_LIMIT.
//     - The frog never rests on row 0.
//  Game inactive:
//   - i_Game_Active=0 forces X/Y to the start tile every cycle.
//   - Score holds; it clears only on i_Rst.
//  Draw flag:
//   - o_Draw_Frogger = ({1'b0,i_Col_Count_Div}==o_Frogger_X) && ({1'b0,i_Row_Count_Div}==o_Frogger_Y).
//   - Combinational, zero latency, so it stays aligned with the pixel counters.
//  Reset has priority over every other event, including a simultaneous goal or move.
// STRUCTURE
//  Shared package frogger_pkg holds:
//   - GAME_WIDTH, GAME_HEIGHT, TILE_SIZE=32, SCORE_LIMIT, START_X, START_Y.
//   - Tile codes: WALL=0, ROAD=1, WATER=2, SAFE=3, LILY=4.
//  One natural sub-module: button_edge_detect (1-bit rising-edge detector with reset-to-1 history), instantiated 4x.
//  Position/score update lives in a single clocked process; the draw compare is continuous assignment.
// TESTING
//  1. Reset with Up held, release reset, hold Up 5 cycles -> X=6, Y=12, no move; drop Up, then pulse Up -> Y=11.
//  2. From the start tile, pulse Down and Right 8x -> Y stays 12, X reaches 13 then stays 13; pulse Left 14x -> X=0.
//  3. Up and Left asserted in the same cycle at (6,12) -> Y=11, X=6 (Up wins).
//  4. Walk to (4,1), pulse Up -> (6,12) and o_Score=1; walk to (5,1), pulse Up -> stays (5,1), score unchanged.
//  5. Preload score to 99 via feedback, then score a goal -> o_Score stays 99 and the frog respawns at (6,12).
//  6. Drop i_Game_Active while at (3,5) -> frog returns to (6,12) and moves are ignored.
//     With col/row div = 6/12 -> o_Draw_Frogger=1; with 7/12 -> 0.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared constants and types for the Frogger game.
// Holds the playfield geometry, respawn tile, score limit, tile codes,
// the per-cycle move request bundle and the saturating score helper.
package frogger_pkg;

  localparam int unsigned GAME_WIDTH  = 14;
  localparam int unsigned GAME_HEIGHT = 13;
  localparam int unsigned TILE_SIZE   = 32;
  localparam int unsigned SCORE_LIMIT = 99;
  localparam int unsigned START_X     = 6;
  localparam int unsigned START_Y     = 12;

  localparam int unsigned POS_W   = 6;
  localparam int unsigned SCORE_W = 7;
  localparam int unsigned DIV_W   = 5;

  typedef enum logic [2:0] {
    TILE_WALL  = 3'd0,
    TILE_ROAD  = 3'd1,
    TILE_WATER = 3'd2,
    TILE_SAFE  = 3'd3,
    TILE_LILY  = 3'd4
  } tile_e;

  // One-cycle rising-edge requests from the four direction buttons
  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } move_req_t;

  // Next score after reaching a lily pad; saturates at SCORE_LIMIT
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s < SCORE_W'(SCORE_LIMIT)) ? s + SCORE_W'(1) : SCORE_W'(SCORE_LIMIT);
  endfunction

endpackage

// File: rtl/button_edge_detect.sv
// 1-bit rising-edge detector for a debounced button level.
// History resets to 1 so a button held through reset release is not a press.
//  i_Clk     in  1  clock
//  i_Rst     in  1  synchronous active-high reset
//  i_Level   in  1  debounced button level
//  o_Rise_c  out 1  combinational: level high now, low on the previous clock
module button_edge_detect (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Level,
  output logic o_Rise_c
);

  logic hist_q;

  // History updates every clock regardless of game state
  always_ff @(posedge i_Clk) begin
    if (i_Rst) hist_q <= 1'b1;
    else       hist_q <= i_Level;
  end

  assign o_Rise_c = i_Level & ~hist_q;

endmodule

// File: rtl/frogger_player_ctrl.sv
// Player-control core: moves the frog one tile per button press on the
// 14x13 grid, scores and respawns on lily-pad arrival, and flags the tile
// currently scanned by the VGA counters when it holds the frog.
//  i_Clk, i_Rst        clock, synchronous active-high reset
//  i_Game_Active       1 = play enabled, 0 = frog held at start tile
//  i_*_Mvt             debounced direction button levels
//  i_Score             score fed back from o_Score, used for the limit check
//  i_Col/Row_Count_Div scanned tile column/row
//  o_Draw_Frogger      combinational: scanned tile is the frog tile
//  o_Frogger_X/Y       registered frog tile
//  o_Score             registered score, 0..SCORE_LIMIT
module frogger_player_ctrl
  import frogger_pkg::*;
(
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Game_Active,
  input  logic               i_Up_Mvt,
  input  logic               i_Down_Mvt,
  input  logic               i_Left_Mvt,
  input  logic               i_Right_Mvt,
  input  logic [SCORE_W-1:0] i_Score,
  input  logic [DIV_W-1:0]   i_Col_Count_Div,
  input  logic [DIV_W-1:0]   i_Row_Count_Div,
  output logic               o_Draw_Frogger,
  output logic [POS_W-1:0]   o_Frogger_X,
  output logic [POS_W-1:0]   o_Frogger_Y,
  output logic [SCORE_W-1:0] o_Score
);

  logic      up_rise, down_rise, left_rise, right_rise;
  move_req_t req;

  button_edge_detect u_up_edge (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Level(i_Up_Mvt), .o_Rise_c(up_rise)
  );
  button_edge_detect u_down_edge (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Level(i_Down_Mvt), .o_Rise_c(down_rise)
  );
  button_edge_detect u_left_edge (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Level(i_Left_Mvt), .o_Rise_c(left_rise)
  );
  button_edge_detect u_right_edge (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Level(i_Right_Mvt), .o_Rise_c(right_rise)
  );

  assign req = '{up: up_rise, down: down_rise, left: left_rise, right: right_rise};

  // Position and score update. The highest-priority request is the only one
  // considered; if it is out of bounds the frog simply stays put this cycle.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Frogger_X <= POS_W'(START_X);
      o_Frogger_Y <= POS_W'(START_Y);
      o_Score     <= '0;
    end else if (!i_Game_Active) begin
      o_Frogger_X <= POS_W'(START_X);
      o_Frogger_Y <= POS_W'(START_Y);
    end else if (req.up) begin
      if (o_Frogger_Y == POS_W'(1)) begin
        // Even goal columns are lily pads, odd ones are walls
        if (!o_Frogger_X[0]) begin
          o_Frogger_X <= POS_W'(START_X);
          o_Frogger_Y <= POS_W'(START_Y);
          o_Score     <= score_inc(i_Score);
        end
      end else if (o_Frogger_Y != '0) begin
        o_Frogger_Y <= o_Frogger_Y - POS_W'(1);
      end
    end else if (req.down) begin
      if (o_Frogger_Y != POS_W'(GAME_HEIGHT - 1)) o_Frogger_Y <= o_Frogger_Y + POS_W'(1);
    end else if (req.left) begin
      if (o_Frogger_X != '0) o_Frogger_X <= o_Frogger_X - POS_W'(1);
    end else if (req.right) begin
      if (o_Frogger_X != POS_W'(GAME_WIDTH - 1)) o_Frogger_X <= o_Frogger_X + POS_W'(1);
    end
  end

  // Zero-latency compare keeps the sprite aligned with the pixel counters
  assign o_Draw_Frogger = ({1'b0, i_Col_Count_Div} == o_Frogger_X) &&
                          ({1'b0, i_Row_Count_Div} == o_Frogger_Y);

endmodule

// File: tb/tb_frogger_player_ctrl.sv
// Self-checking bench for frogger_player_ctrl: directed scenarios followed by
// randomized button/active/reset traffic, all compared against an
// integer-level game model kept in the bench.
module tb_frogger_player_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       act = 1'b1;
  logic       up = 1'b0, dn = 1'b0, lf = 1'b0, rt = 1'b0;
  logic [6:0] score_in = '0;
  logic [4:0] col = '0, row = '0;

  logic       draw;
  logic [5:0] fx, fy;
  logic [6:0] score;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: frog tile, score, and the last sampled button levels
  int  m_x = 6, m_y = 12, m_score = 0;
  bit  h_up = 1, h_dn = 1, h_lf = 1, h_rt = 1;
  bit  use_fb = 1;

  always #5 clk = ~clk;

  frogger_player_ctrl dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Game_Active  (act),
    .i_Up_Mvt       (up),
    .i_Down_Mvt     (dn),
    .i_Left_Mvt     (lf),
    .i_Right_Mvt    (rt),
    .i_Score        (score_in),
    .i_Col_Count_Div(col),
    .i_Row_Count_Div(row),
    .o_Draw_Frogger (draw),
    .o_Frogger_X    (fx),
    .o_Frogger_Y    (fy),
    .o_Score        (score)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Game rules applied once per rising clock edge
  task automatic model_edge();
    bit ru, rd, rl, rr;
    if (rst) begin
      m_x = 6; m_y = 12; m_score = 0;
      h_up = 1; h_dn = 1; h_lf = 1; h_rt = 1;
      return;
    end
    ru = up && !h_up; rd = dn && !h_dn; rl = lf && !h_lf; rr = rt && !h_rt;
    h_up = up; h_dn = dn; h_lf = lf; h_rt = rt;
    if (!act) begin
      m_x = 6; m_y = 12;
    end else if (ru) begin
      if (m_y == 1 && (m_x % 2) == 0) begin
        m_x = 6; m_y = 12;
        m_score = (int'(score_in) < 99) ? int'(score_in) + 1 : 99;
      end else if (m_y >= 2) begin
        m_y = m_y - 1;
      end
    end else if (rd) begin
      if (m_y < 12) m_y = m_y + 1;
    end else if (rl) begin
      if (m_x > 0) m_x = m_x - 1;
    end else if (rr) begin
      if (m_x < 13) m_x = m_x + 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".x"}, 32'(fx), 32'(m_x));
    chk({tag, ".y"}, 32'(fy), 32'(m_y));
    chk({tag, ".score"}, 32'(score), 32'(m_score));
    chk({tag, ".draw"}, 32'(draw), 32'((int'(col) == m_x) && (int'(row) == m_y)));
  endtask

  // One clock with the given button levels, then check
  task automatic cyc(input string tag, input logic u, input logic d, input logic l, input logic r);
    up = u; dn = d; lf = l; rt = r;
    if (use_fb) score_in = 7'(m_score);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // n press/release pairs on one direction: 0=up 1=down 2=left 3=right
  task automatic pulse(input string tag, input int dir, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(tag, dir == 0, dir == 1, dir == 2, dir == 3);
      cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    // 1: reset with Up held, held through release, then a clean press
    rst = 1'b1;
    cyc("reset", 1, 0, 0, 0);
    cyc("reset", 1, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc("held_up", 1, 0, 0, 0);
    cyc("release_up", 0, 0, 0, 0);
    cyc("press_up", 1, 0, 0, 0);
    cyc("release_up2", 0, 0, 0, 0);

    // 2: bounds on bottom row and both side edges
    pulse("down_back", 1, 1);
    pulse("down_bound", 1, 8);
    pulse("right_bound", 3, 8);
    pulse("left_bound", 2, 14);

    // 3: Up beats Left
    act = 1'b0;
    cyc("inactive_home", 0, 0, 0, 0);
    act = 1'b1;
    cyc("up_left", 1, 0, 1, 0);
    cyc("up_left_rel", 0, 0, 0, 0);

    // 4: lily pad at column 4, wall at column 5
    pulse("walk_l", 2, 2);
    pulse("walk_u", 0, 10);
    pulse("goal_lily", 0, 1);
    pulse("walk_l2", 2, 1);
    pulse("walk_u2", 0, 11);
    pulse("goal_wall", 0, 1);

    // 5: saturation with externally preloaded score
    use_fb = 0;
    score_in = 7'd99;
    pulse("walk_l3", 2, 1);
    pulse("goal_sat", 0, 1);
    score_in = 7'd98;
    pulse("walk_u3", 0, 11);
    pulse("goal_98", 0, 1);
    use_fb = 1;

    // 6: game inactive returns frog home and blocks moves; draw flag
    pulse("walk_l4", 2, 3);
    pulse("walk_u4", 0, 7);
    act = 1'b0;
    cyc("inactive", 0, 0, 0, 0);
    pulse("inactive_up", 0, 2);
    pulse("inactive_rt", 3, 2);
    col = 5'd6; row = 5'd12;
    #1 chk("draw_hit", 32'(draw), 32'd1);
    col = 5'd7;
    #1 chk("draw_miss", 32'(draw), 32'd0);
    act = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      act = ($urandom_range(0, 19) != 0);
      use_fb = ($urandom_range(0, 7) != 0);
      if (!use_fb) score_in = 7'($urandom_range(90, 127));
      if ($urandom_range(0, 1) == 1) begin
        col = 5'(m_x); row = 5'(m_y);
      end else begin
        col = 5'($urandom_range(0, 31)); row = 5'($urandom_range(0, 31));
      end
      // Bias toward Up so goals are reached occasionally
      cyc("rand", $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
